// File: rtl/spi_bridge_pkg.sv
// Shared types and constants for the SPI register bridge.
package spi_bridge_pkg;

    // Bridge access state
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } state_e;

    // Bus width codes (shared by txn_width, data_write_n, data_read_n)
    localparam logic [1:0] W8    = 2'b00;
    localparam logic [1:0] W16   = 2'b01;
    localparam logic [1:0] W32   = 2'b10;
    localparam logic [1:0] WNONE = 2'b11;

    // Read data returned when the peripheral never answers
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    // Zero-extend peripheral read data according to the access width
    function automatic logic [31:0] zext_by_width(input logic [31:0] d, input logic [1:0] w);
        case (w)
            W8:      return {24'h00_0000, d[7:0]};
            W16:     return {16'h0000, d[15:0]};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/bridge_timer.sv
// Access timeout counter; only built when SPI_BRIDGE_TIMEOUT_EN is defined.
`ifdef SPI_BRIDGE_TIMEOUT_EN
module bridge_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rstb,
    input  logic load,
    input  logic count,
    output logic expire_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Expire on the last waiting cycle so the FSM leaves after TIMEOUT_CYCLES cycles
    assign expire_c = count && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Clear on load, otherwise count up while an access waits
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = '0;
        end else if (count && !expire_c) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (!rstb) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`endif

// File: rtl/spi_periph_bridge.sv
// SPI register transactions to peripheral-bus accesses.
// Optional access timeout: define SPI_BRIDGE_TIMEOUT_EN.
module spi_periph_bridge
    import spi_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W         = 6,
    parameter int unsigned REG_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic [ADDR_W-1:0] reg_addr,
    input  logic [REG_W-1:0]  reg_data_o,
    input  logic              reg_data_o_dv,
    input  logic              reg_addr_v,
    input  logic              reg_rw,
    input  logic [1:0]        txn_width,
    output logic [REG_W-1:0]  reg_data_i,
    output logic [ADDR_W-1:0] address,
    output logic [REG_W-1:0]  data_in,
    output logic [1:0]        data_write_n,
    output logic [1:0]        data_read_n,
    input  logic [REG_W-1:0]  data_out,
    input  logic              data_ready,
    output logic              busy,
    output logic              err
);

    state_e            state_q, state_d;
    logic              addr_v_q, addr_v_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [REG_W-1:0]  data_in_q, data_in_d;
    logic [REG_W-1:0]  reg_data_i_q, reg_data_i_d;
    logic [1:0]        write_n_q, write_n_d;
    logic [1:0]        read_n_q, read_n_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic              wr_req_c;
    logic              rd_req_c;
    logic              timer_expire_c;

    // Write completes on the strobe; read fires once on the rising edge of addr_v
    assign wr_req_c = reg_data_o_dv & reg_rw;
    assign rd_req_c = reg_addr_v & ~addr_v_q & ~reg_rw;

`ifdef SPI_BRIDGE_TIMEOUT_EN
    // Counter is cleared while idle and runs for the whole access
    bridge_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rstb     (rstb),
        .load     (state_q == IDLE),
        .count    (state_q != IDLE),
        .expire_c (timer_expire_c)
    );
`else
    assign timer_expire_c = 1'b0;
`endif

    // Next-state and registered output logic
    always_comb begin
        state_d      = state_q;
        addr_v_d     = reg_addr_v;
        address_d    = address_q;
        data_in_d    = data_in_q;
        reg_data_i_d = reg_data_i_q;
        write_n_d    = write_n_q;
        read_n_d     = read_n_q;
        busy_d       = busy_q;
        err_d        = err_q;

        case (state_q)
            IDLE: begin
                if (wr_req_c) begin
                    if (rd_req_c) begin
                        err_d = 1'b1;
                    end
                    if (txn_width == WNONE) begin
                        err_d = 1'b1;
                    end else begin
                        state_d   = WR;
                        address_d = reg_addr;
                        data_in_d = reg_data_o;
                        write_n_d = txn_width;
                        busy_d    = 1'b1;
                    end
                end else if (rd_req_c) begin
                    reg_data_i_d = '0;
                    if (txn_width == WNONE) begin
                        err_d = 1'b1;
                    end else begin
                        state_d   = RD;
                        address_d = reg_addr;
                        read_n_d  = txn_width;
                        busy_d    = 1'b1;
                    end
                end
            end

            WR, RD: begin
                // Only one access may be outstanding; later requests are lost
                if (wr_req_c || rd_req_c) begin
                    err_d = 1'b1;
                end
                if (data_ready) begin
                    state_d   = IDLE;
                    write_n_d = WNONE;
                    read_n_d  = WNONE;
                    busy_d    = 1'b0;
                    if (state_q == RD) begin
                        reg_data_i_d = REG_W'(zext_by_width(32'(data_out), read_n_q));
                    end
                end else if (timer_expire_c) begin
                    state_d   = IDLE;
                    write_n_d = WNONE;
                    read_n_d  = WNONE;
                    busy_d    = 1'b0;
                    err_d     = 1'b1;
                    if (state_q == RD) begin
                        reg_data_i_d = REG_W'(TIMEOUT_DATA);
                    end
                end
            end

            default: begin
                state_d   = IDLE;
                write_n_d = WNONE;
                read_n_d  = WNONE;
                busy_d    = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q      <= IDLE;
            addr_v_q     <= 1'b0;
            address_q    <= '0;
            data_in_q    <= '0;
            reg_data_i_q <= '0;
            write_n_q    <= WNONE;
            read_n_q     <= WNONE;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_v_q     <= addr_v_d;
            address_q    <= address_d;
            data_in_q    <= data_in_d;
            reg_data_i_q <= reg_data_i_d;
            write_n_q    <= write_n_d;
            read_n_q     <= read_n_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    assign reg_data_i   = reg_data_i_q;
    assign address      = address_q;
    assign data_in      = data_in_q;
    assign data_write_n = write_n_q;
    assign data_read_n  = read_n_q;
    assign busy         = busy_q;
    assign err          = err_q;

endmodule
